fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline. It owns the program counter, issues instruction-memory reads, and drives the write side of the IF/ID pipeline register (`instruction_in`, `next_address_in`, `WEN`, `flush`). It holds on hazard stalls without losing a returned instruction, squashes on branch/jump redirect, and stops fetching on HALT.

---
 rtl/fetch_stage.sv | 115 +++++++++++
 tb/tb_fetch_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction reads and drives the write side
// of the IF/ID register, with a one-entry hold buffer for stalls, redirect squash and HALT.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        iREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        ifid_WEN,
  output logic        ifid_flush,
  output logic [31:0] instruction_in,
  output logic [31:0] next_address_in,
  output logic        halt,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StHalted
  } state_e;

  state_e      r_state_q, r_state_d;
  logic [31:0] r_pc_q, r_pc_d;
  logic [31:0] r_buf_q, r_buf_d;
  logic [31:0] r_count_q, r_count_d;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;

  assign w_pc_plus4    = r_pc_q + 32'd4;
  assign w_redirect_pc = redirect_addr & 32'hFFFF_FFFC;
  assign imemaddr      = r_pc_q;
  assign fetch_count   = r_count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state_q <= StFetch;
      r_pc_q    <= RESET_PC;
      r_buf_q   <= '0;
      r_count_q <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_pc_q    <= r_pc_d;
      r_buf_q   <= r_buf_d;
      r_count_q <= r_count_d;
    end
  end

  always_comb begin
    r_state_d       = r_state_q;
    r_pc_d          = r_pc_q;
    r_buf_d         = r_buf_q;
    r_count_d       = r_count_q;
    iREN            = 1'b0;
    ifid_WEN        = 1'b0;
    ifid_flush      = 1'b0;
    halt            = 1'b0;
    instruction_in  = imemload;
    next_address_in = w_pc_plus4;

    if (!RST) begin
      halt = (r_state_q == StHalted);
      iREN = (r_state_q == StFetch);
      if (redirect) begin
        // Squash: any returned or buffered instruction belongs to the wrong path.
        ifid_flush = 1'b1;
        r_pc_d     = w_redirect_pc;
        r_state_d  = StFetch;
        r_buf_d    = '0;
      end else begin
        unique case (r_state_q)
          StFetch: begin
            if (ihit) begin
              if (stall) begin
                r_buf_d   = imemload;
                r_state_d = StHold;
              end else begin
                ifid_WEN  = 1'b1;
                r_count_d = r_count_q + 32'd1;
                if (imemload == HALT_WORD) begin
                  r_state_d = StHalted;
                end else begin
                  r_pc_d = w_pc_plus4;
                end
              end
            end
          end
          StHold: begin
            instruction_in = r_buf_q;
            if (!stall) begin
              ifid_WEN  = 1'b1;
              r_pc_d    = w_pc_plus4;
              r_count_d = r_count_q + 32'd1;
              r_state_d = (r_buf_q == HALT_WORD) ? StHalted : StFetch;
            end
          end
          StHalted: begin
          end
          default: begin
            r_state_d = StFetch;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [31:0] imemload = '0, redirect_addr = '0;
  logic        iREN, ifid_WEN, ifid_flush, halt;
  logic [31:0] imemaddr, instruction_in, next_address_in, fetch_count;

  // Second instance exercises the wrapping reset PC.
  logic        w_RST = 1'b1;
  logic        w_ihit = 1'b0, w_stall = 1'b0, w_redirect = 1'b0;
  logic [31:0] w_imemload = '0, w_redirect_addr = '0;
  logic        w_iREN, w_ifid_WEN, w_ifid_flush, w_halt;
  logic [31:0] w_imemaddr, w_instruction_in, w_next_address_in, w_fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  logic [31:0] m_pc = '0, m_buf = '0, m_count = '0;
  bit          m_halted = 0, m_buffered = 0;
  // Expected outputs for the current (pre-edge) cycle
  logic        e_iren, e_wen, e_flush, e_halt;
  logic [31:0] e_addr, e_instr, e_next, e_count;

  always #5 CLK = ~CLK;

  fetch_stage dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .imemaddr(imemaddr), .ihit(ihit),
    .imemload(imemload), .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
    .ifid_WEN(ifid_WEN), .ifid_flush(ifid_flush), .instruction_in(instruction_in),
    .next_address_in(next_address_in), .halt(halt), .fetch_count(fetch_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .HALT_WORD(32'hFFFF_FFFF)) dut_w (
    .CLK(CLK), .RST(w_RST), .iREN(w_iREN), .imemaddr(w_imemaddr), .ihit(w_ihit),
    .imemload(w_imemload), .stall(w_stall), .redirect(w_redirect),
    .redirect_addr(w_redirect_addr), .ifid_WEN(w_ifid_WEN), .ifid_flush(w_ifid_flush),
    .instruction_in(w_instruction_in), .next_address_in(w_next_address_in), .halt(w_halt),
    .fetch_count(w_fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] r;
    r = (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    if (r == HALT) r = '0;
    return r;
  endfunction

  // Apply inputs away from the rising edge and derive expected outputs from the model.
  task automatic drive(input bit rst, input bit ih, input bit st, input bit rd,
                       input logic [31:0] ra, input bit hw);
    @(negedge CLK);
    RST = rst; ihit = ih; stall = st; redirect = rd; redirect_addr = ra;
    imemload = hw ? HALT : (ih ? mem_word(m_pc) : $urandom);
    #1;
    e_addr = m_pc; e_count = m_count; e_instr = imemload; e_next = m_pc + 32'd4;
    e_iren = 0; e_wen = 0; e_flush = 0; e_halt = 0;
    if (!rst) begin
      e_halt = m_halted;
      if (rd) begin
        e_flush = 1;
      end else if (m_halted) begin
        e_wen = 0;
      end else if (m_buffered) begin
        e_wen   = !st;
        e_instr = m_buf;
      end else begin
        e_iren = 1;
        e_wen  = ih && !st;
      end
    end
  endtask

  task automatic advance();
    @(posedge CLK);
    if (RST) begin
      m_pc = '0; m_halted = 0; m_buffered = 0; m_count = '0;
    end else if (redirect) begin
      m_pc = redirect_addr & ~32'h3; m_halted = 0; m_buffered = 0;
    end else if (m_halted) begin
      m_pc = m_pc;
    end else if (m_buffered) begin
      if (!stall) begin
        m_count++; m_pc += 4; m_buffered = 0; m_halted = (m_buf == HALT);
      end
    end else if (ihit) begin
      if (stall) begin
        m_buffered = 1; m_buf = imemload;
      end else begin
        m_count++;
        if (imemload == HALT) m_halted = 1;
        else m_pc += 4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 1, 32'h40, 0);
    n_cmp++;
    if ({iREN, ifid_WEN, ifid_flush, halt} !== 4'b0000) begin
      n_err++; $display("FAIL reset_outputs: got %b want 0000", {iREN, ifid_WEN, ifid_flush, halt});
    end
    advance();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (imemaddr !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", imemaddr); end
    n_cmp++;
    if (fetch_count !== 32'h0) begin
      n_err++; $display("FAIL reset_count: got %0d want 0", fetch_count);
    end
    n_cmp++;
    if (iREN !== 1'b1) begin n_err++; $display("FAIL reset_iren: got %b want 1", iREN); end
    advance();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      n_cmp++;
      if (ifid_WEN !== 1'b1 || instruction_in !== mem_word(32'(4 * i)) ||
          next_address_in !== 32'(4 * i + 4)) begin
        n_err++;
        $display("FAIL seq_write[%0d]: got wen=%b %h,%h want 1 %h,%h", i, ifid_WEN,
                 instruction_in, next_address_in, mem_word(32'(4 * i)), 32'(4 * i + 4));
      end
      advance();
    end
    n_cmp++;
    if (fetch_count !== 32'd4 || imemaddr !== 32'd16) begin
      n_err++; $display("FAIL seq_count: got %0d pc=%h want 4 pc=10", fetch_count, imemaddr);
    end
  endtask

  task automatic test_stall_hold();
    drive(1, 0, 0, 0, 0, 0); advance();
    for (int i = 0; i < 2; i++) begin drive(0, 1, 0, 0, 0, 0); advance(); end
    drive(0, 1, 1, 0, 0, 0);
    n_cmp++;
    if (ifid_WEN !== 1'b0 || imemaddr !== 32'd8) begin
      n_err++; $display("FAIL stall_capture: got wen=%b pc=%h want 0 8", ifid_WEN, imemaddr);
    end
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 0, 0, 0);
      n_cmp++;
      if (iREN !== 1'b0 || ifid_WEN !== 1'b0 || imemaddr !== 32'd8) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got iren=%b wen=%b pc=%h want 0 0 8", i, iREN,
                 ifid_WEN, imemaddr);
      end
      advance();
    end
    drive(0, 1, 0, 0, 0, 0);
    n_cmp++;
    if (iREN !== 1'b0 || ifid_WEN !== 1'b1 || instruction_in !== mem_word(32'd8) ||
        next_address_in !== 32'd12) begin
      n_err++;
      $display("FAIL stall_release: got iren=%b wen=%b %h,%h want 0 1 %h,0000000c", iREN,
               ifid_WEN, instruction_in, next_address_in, mem_word(32'd8));
    end
    advance();
    n_cmp++;
    if (imemaddr !== 32'd12 || fetch_count !== 32'd3) begin
      n_err++; $display("FAIL stall_after: got pc=%h cnt=%0d want c 3", imemaddr, fetch_count);
    end
  endtask

  task automatic test_redirect();
    drive(0, 1, 1, 1, 32'h0000_0043, 0);
    n_cmp++;
    if (ifid_flush !== 1'b1 || ifid_WEN !== 1'b0) begin
      n_err++; $display("FAIL redir_flush: got flush=%b wen=%b want 1 0", ifid_flush, ifid_WEN);
    end
    advance();
    n_cmp++;
    if (imemaddr !== 32'h40 || fetch_count !== 32'd3) begin
      n_err++; $display("FAIL redir_pc: got pc=%h cnt=%0d want 40 3", imemaddr, fetch_count);
    end
    drive(0, 0, 1, 0, 0, 0);
    n_cmp++;
    if (iREN !== 1'b1) begin n_err++; $display("FAIL redir_nohold: got iren=%b want 1", iREN); end
    advance();
    drive(0, 1, 0, 0, 0, 0);
    n_cmp++;
    if (ifid_WEN !== 1'b1 || instruction_in !== mem_word(32'h40)) begin
      n_err++;
      $display("FAIL redir_target: got wen=%b %h want 1 %h", ifid_WEN, instruction_in,
               mem_word(32'h40));
    end
    advance();
  endtask

  task automatic test_halt();
    logic [31:0] cnt0;
    drive(0, 0, 0, 1, 32'h20, 0); advance();
    cnt0 = fetch_count;
    drive(0, 1, 0, 0, 0, 1);
    n_cmp++;
    if (ifid_WEN !== 1'b1 || instruction_in !== HALT || halt !== 1'b0) begin
      n_err++;
      $display("FAIL halt_write: got wen=%b %h halt=%b want 1 ffffffff 0", ifid_WEN,
               instruction_in, halt);
    end
    advance();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1'($urandom), 0, 0, 0);
      n_cmp++;
      if (halt !== 1'b1 || iREN !== 1'b0 || ifid_WEN !== 1'b0 || imemaddr !== 32'h20 ||
          fetch_count !== cnt0 + 32'd1) begin
        n_err++;
        $display("FAIL halt_hold[%0d]: got halt=%b iren=%b wen=%b pc=%h cnt=%0d", i, halt,
                 iREN, ifid_WEN, imemaddr, fetch_count);
      end
      advance();
    end
    drive(0, 1, 0, 1, 32'h100, 0);
    n_cmp++;
    if (ifid_flush !== 1'b1) begin n_err++; $display("FAIL halt_redir: got flush=0 want 1"); end
    advance();
    drive(0, 1, 0, 0, 0, 0);
    n_cmp++;
    if (halt !== 1'b0 || imemaddr !== 32'h100 || ifid_WEN !== 1'b1 ||
        instruction_in !== mem_word(32'h100)) begin
      n_err++;
      $display("FAIL halt_resume: got halt=%b pc=%h wen=%b %h", halt, imemaddr, ifid_WEN,
               instruction_in);
    end
    advance();
  endtask

  task automatic test_random();
    drive(1, 0, 0, 0, 0, 0); advance();
    for (int c = 0; c < 600; c++) begin
      bit rd, st, ih, hw;
      rd = ($urandom_range(15) == 0);
      st = ($urandom_range(3) == 0);
      ih = ($urandom_range(3) != 0);
      hw = ih && ($urandom_range(19) == 0);
      drive(0, ih, st, rd, $urandom, hw);
      n_cmp++;
      if (imemaddr !== e_addr || fetch_count !== e_count || halt !== e_halt ||
          ifid_WEN !== e_wen || ifid_flush !== e_flush || (!rd && iREN !== e_iren) ||
          (e_wen && (instruction_in !== e_instr || next_address_in !== e_next))) begin
        n_err++;
        $display("FAIL rand[%0d]: got pc=%h cnt=%0d h=%b w=%b f=%b r=%b %h,%h want pc=%h cnt=%0d h=%b w=%b f=%b r=%b %h,%h",
                 c, imemaddr, fetch_count, halt, ifid_WEN, ifid_flush, iREN, instruction_in,
                 next_address_in, e_addr, e_count, e_halt, e_wen, e_flush, e_iren, e_instr,
                 e_next);
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    @(negedge CLK); w_RST = 1; w_ihit = 0; w_stall = 0;
    @(negedge CLK); w_RST = 0; w_ihit = 1; w_imemload = 32'h1234_5678;
    #1;
    n_cmp++;
    if (w_imemaddr !== 32'hFFFF_FFFC || w_ifid_WEN !== 1'b1 || w_next_address_in !== 32'h0 ||
        w_instruction_in !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL wrap_fetch: got pc=%h wen=%b %h,%h want fffffffc 1 12345678,0",
               w_imemaddr, w_ifid_WEN, w_instruction_in, w_next_address_in);
    end
    @(negedge CLK); w_stall = 1; w_imemload = 32'hCAFE_0000;
    #1;
    n_cmp++;
    if (w_imemaddr !== 32'h0 || w_fetch_count !== 32'd1) begin
      n_err++; $display("FAIL wrap_pc: got pc=%h cnt=%0d want 0 1", w_imemaddr, w_fetch_count);
    end
    @(negedge CLK);
    #1;
    n_cmp++;
    if (w_iREN !== 1'b0 || w_ifid_WEN !== 1'b0) begin
      n_err++; $display("FAIL wrap_hold: got iren=%b wen=%b want 0 0", w_iREN, w_ifid_WEN);
    end
    @(negedge CLK); w_RST = 1;
    @(negedge CLK); w_RST = 0; w_ihit = 0;
    #1;
    n_cmp++;
    if (w_imemaddr !== 32'hFFFF_FFFC || w_fetch_count !== 32'd0 || w_iREN !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_rst_hold: got pc=%h cnt=%0d iren=%b want fffffffc 0 1", w_imemaddr,
               w_fetch_count, w_iREN);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_hold();
    test_redirect();
    test_halt();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
